max7219_chain: RTL and testbench

//   Write-only serial driver for a daisy chain of NUM_DEVICES MAX7219 display controllers.

---
 rtl/max7219_pkg.sv | 28 ++
 rtl/max7219_bit_timer.sv | 51 +++++
 rtl/max7219_chain.sv | 144 ++++++++++++++
 tb/tb_max7219_chain.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 chain driver: register map, word width, FSM encoding.
package max7219_pkg;

  localparam int unsigned WORD_W = 16;

  localparam logic [3:0] REG_NOOP       = 4'h0;
  localparam logic [3:0] REG_DIGIT0     = 4'h1;
  localparam logic [3:0] REG_DIGIT1     = 4'h2;
  localparam logic [3:0] REG_DIGIT2     = 4'h3;
  localparam logic [3:0] REG_DIGIT3     = 4'h4;
  localparam logic [3:0] REG_DIGIT4     = 4'h5;
  localparam logic [3:0] REG_DIGIT5     = 4'h6;
  localparam logic [3:0] REG_DIGIT6     = 4'h7;
  localparam logic [3:0] REG_DIGIT7     = 4'h8;
  localparam logic [3:0] REG_DECODE     = 4'h9;
  localparam logic [3:0] REG_INTENSITY  = 4'hA;
  localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
  localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
  localparam logic [3:0] REG_DISP_TEST  = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/max7219_bit_timer.sv
// Serial-clock phase divider. While enabled, alternates CLK_DIV-cycle low and high
// phases starting with low; ticks flag the last cycle of each phase.
//   i_clk, i_reset : clock, async active-high reset
//   i_en           : run; deasserting restarts at the beginning of a low phase
//   o_rise_tick_c  : last cycle of a low phase (next cycle is high)
//   o_fall_tick_c  : last cycle of a high phase (next cycle is low, next bit)
module max7219_bit_timer #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_en,
  output logic o_fall_tick_c,
  output logic o_rise_tick_c
);

  localparam int unsigned PH_W = $clog2(CLK_DIV) + 1;

  logic [PH_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            phase_end_c;

  // Phase counter and current serial-clock level
  always_comb begin
    cnt_d       = cnt_q;
    level_d     = level_q;
    phase_end_c = (cnt_q == PH_W'(CLK_DIV - 1));
    if (!i_en) begin
      cnt_d   = '0;
      level_d = 1'b0;
    end else if (phase_end_c) begin
      cnt_d   = '0;
      level_d = ~level_q;
    end else begin
      cnt_d = cnt_q + PH_W'(1);
    end
    o_rise_tick_c = i_en && phase_end_c && !level_q;
    o_fall_tick_c = i_en && phase_end_c && level_q;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/max7219_chain.sv
// Write-only serial driver for a daisy chain of MAX7219s. One strobe sends a full
// frame: the target word to the selected device (or all, on broadcast), no-ops elsewhere.
//   i_stb/i_broadcast/i_dev_sel/i_addr/i_data : write request, captured in IDLE
//   o_busy : frame in progress     o_ack : one-cycle pulse after the latch
//   o_serial_dout/o_serial_clk/o_serial_load : chip pins (DIN, CLK, LOAD)
module max7219_chain #(
  parameter  int unsigned NUM_DEVICES = 4,
  parameter  int unsigned CLK_DIV     = 2,
  parameter  int unsigned LOAD_CYCLES = 2,
  localparam int unsigned DEV_W       = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_stb,
  input  logic             i_broadcast,
  input  logic [DEV_W-1:0] i_dev_sel,
  input  logic [3:0]       i_addr,
  input  logic [7:0]       i_data,
  output logic             o_busy,
  output logic             o_ack,
  output logic             o_serial_dout,
  output logic             o_serial_clk,
  output logic             o_serial_load
);
  import max7219_pkg::*;

  localparam int unsigned FRAME_W = WORD_W * NUM_DEVICES;
  localparam int unsigned BIT_W   = $clog2(FRAME_W) + 1;
  localparam int unsigned LD_W    = $clog2(LOAD_CYCLES) + 1;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [LD_W-1:0]    ld_cnt_q, ld_cnt_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               sclk_q, sclk_d;
  logic               load_q, load_d;
  logic [FRAME_W-1:0] cap_frame_c;
  logic               fall_tick_c, rise_tick_c;

  max7219_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_en          (state_q == ST_SHIFT),
    .o_fall_tick_c (fall_tick_c),
    .o_rise_tick_c (rise_tick_c)
  );

  // Frame image at capture; highest device occupies the MSBs so it is shifted out first
  always_comb begin
    cap_frame_c = '0;
    for (int d = 0; d < int'(NUM_DEVICES); d++) begin
      if (i_broadcast || (i_dev_sel == DEV_W'(d))) begin
        cap_frame_c[d*WORD_W +: WORD_W] = {4'h0, i_addr, i_data};
      end
    end
  end

  // Next-state and registered-output logic. The frame register's MSB drives DIN
  // directly; the final shift leaves it all-zero, so DIN is low during LATCH.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    sclk_d    = sclk_q;
    load_d    = load_q;
    case (state_q)
      ST_IDLE: begin
        if (i_stb) begin
          state_d   = ST_SHIFT;
          frame_d   = cap_frame_c;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          load_d    = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (rise_tick_c) begin
          sclk_d = 1'b1;
        end else if (fall_tick_c) begin
          sclk_d  = 1'b0;
          frame_d = {frame_q[FRAME_W-2:0], 1'b0};
          if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
            state_d  = ST_LATCH;
            load_d   = 1'b1;
            ld_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      ST_LATCH: begin
        if (ld_cnt_q == LD_W'(LOAD_CYCLES - 1)) begin
          state_d = ST_DONE;
          load_d  = 1'b0;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
        end else begin
          ld_cnt_d = ld_cnt_q + LD_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      bit_cnt_q <= '0;
      ld_cnt_q  <= '0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      sclk_q    <= 1'b0;
      load_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      sclk_q    <= sclk_d;
      load_q    <= load_d;
    end
  end

  assign o_busy        = busy_q;
  assign o_ack         = ack_q;
  assign o_serial_dout = frame_q[FRAME_W-1];
  assign o_serial_clk  = sclk_q;
  assign o_serial_load = load_q;

endmodule

// File: tb/tb_max7219_chain.sv
// Bench for max7219_chain with a 3-deep MAX7219 mock chain and a frame scoreboard.
module tb_max7219_chain;
  import max7219_pkg::*;

  localparam int unsigned NDEV     = 3;
  localparam int          BUSY_EXP = 32 * 3 * 2 + 2;

  typedef struct {
    logic        bc;
    logic [1:0]  sel;
    logic [3:0]  addr;
    logic [7:0]  data;
    logic [47:0] frame;
  } vec_t;

  typedef struct {
    logic [47:0] frame;
    int          rises;
  } obs_t;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_stb = 1'b0;
  logic       i_broadcast = 1'b0;
  logic [1:0] i_dev_sel = 2'd0;
  logic [3:0] i_addr = 4'h0;
  logic [7:0] i_data = 8'h00;
  logic       o_busy, o_ack, o_serial_dout, o_serial_clk, o_serial_load;

  max7219_chain #(.NUM_DEVICES(3), .CLK_DIV(2), .LOAD_CYCLES(2)) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_stb         (i_stb),
    .i_broadcast   (i_broadcast),
    .i_dev_sel     (i_dev_sel),
    .i_addr        (i_addr),
    .i_data        (i_data),
    .o_busy        (o_busy),
    .o_ack         (o_ack),
    .o_serial_dout (o_serial_dout),
    .o_serial_clk  (o_serial_clk),
    .o_serial_load (o_serial_load)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- MAX7219 mock chain ----------------
  logic [47:0] chain = '0;
  int          rises = 0;
  logic [7:0]  mock_reg [3][16] = '{default: '{default: 8'h00}};
  obs_t        obs_q[$];
  logic [47:0] exp_q[$];
  int          busy_total = 0;
  int          ack_total = 0;
  int          glitch_cnt = 0;

  always @(posedge o_serial_clk) chain <= {chain[46:0], o_serial_dout};

  // Rising-edge count since the last load falling edge or reset
  always @(posedge o_serial_clk or posedge i_reset or negedge o_serial_load) begin
    if (i_reset)           rises <= 0;
    else if (o_serial_clk) rises <= rises + 1;
    else                   rises <= 0;
  end

  always @(posedge o_serial_load) begin
    obs_t o;
    o.frame = chain;
    o.rises = rises;
    obs_q.push_back(o);
    for (int d = 0; d < 3; d++) begin
      if (chain[16*d+8 +: 4] != 4'h0) mock_reg[d][chain[16*d+8 +: 4]] <= chain[16*d +: 8];
    end
  end

  always @(o_serial_dout) if (o_serial_clk) glitch_cnt <= glitch_cnt + 1;

  always @(negedge i_clk) begin
    if (o_busy) busy_total <= busy_total + 1;
    if (o_ack)  ack_total  <= ack_total + 1;
  end

  // ---------------- checking ----------------
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_regs [3][16] = '{default: '{default: 8'h00}};
  vec_t       vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, 64'({o_busy, o_ack, o_serial_dout, o_serial_clk, o_serial_load}), 64'd0);
  endtask

  task automatic update_regs(input vec_t v);
    for (int d = 0; d < 3; d++) begin
      if ((v.bc || v.sel == 2'(d)) && v.addr != REG_NOOP) exp_regs[d][v.addr] = v.data;
    end
  endtask

  task automatic check_regs(input string name);
    int mism = 0;
    for (int d = 0; d < 3; d++)
      for (int r = 0; r < 16; r++)
        if (mock_reg[d][r] !== exp_regs[d][r]) mism++;
    check(name, 64'(mism), 64'd0);
  endtask

  task automatic launch(input vec_t v);
    @(negedge i_clk);
    i_stb = 1'b1; i_broadcast = v.bc; i_dev_sel = v.sel; i_addr = v.addr; i_data = v.data;
    @(negedge i_clk);
    i_stb = 1'b0;
    i_broadcast = 1'($urandom); i_dev_sel = 2'($urandom); i_addr = 4'($urandom); i_data = 8'($urandom);
  endtask

  task automatic pop_compare(input string name);
    obs_t o;
    logic [47:0] e;
    e = exp_q.pop_front();
    if (obs_q.size() > 0) o = obs_q.pop_front();
    else begin o.frame = 'x; o.rises = -1; end
    check({name, "_frame"}, 64'(o.frame), 64'(e));
    check({name, "_rises"}, 64'(o.rises), 64'd48);
  endtask

  // Sends one frame; optionally pulses a conflicting strobe 'inject' cycles in
  task automatic do_frame(input vec_t v, input int inject, input string name);
    int b0, a0;
    bit seen;
    b0 = busy_total; a0 = ack_total;
    exp_q.push_back(v.frame);
    launch(v);
    seen = 1'b0;
    for (int i = 1; i < 600 && !seen; i++) begin
      @(negedge i_clk);
      if (i == inject) begin
        i_stb = 1'b1; i_broadcast = 1'b1; i_addr = REG_DISP_TEST; i_data = 8'hFF;
      end else begin
        i_stb = 1'b0;
      end
      if (o_ack) seen = 1'b1;
    end
    i_stb = 1'b0;
    check({name, "_ack_seen"}, 64'(seen), 64'd1);
    repeat (3) @(negedge i_clk);
    check({name, "_busy_cycles"}, 64'(busy_total - b0), 64'(BUSY_EXP));
    check({name, "_ack_count"}, 64'(ack_total - a0), 64'd1);
    check({name, "_load_count"}, 64'(obs_q.size()), 64'd1);
    pop_compare(name);
    update_regs(v);
    check_regs({name, "_regs"});
  endtask

  initial begin
    vec_t vh;
    bit   seen;
    int   a0;

    vecs[0] = '{1'b0, 2'd1, REG_INTENSITY,  8'h07, 48'h0000_0A07_0000};
    vecs[1] = '{1'b1, 2'd0, REG_SHUTDOWN,   8'h01, 48'h0C01_0C01_0C01};
    vecs[2] = '{1'b0, 2'd3, REG_DECODE,     8'hFF, 48'h0000_0000_0000};
    vecs[3] = '{1'b0, 2'd2, REG_SCAN_LIMIT, 8'h07, 48'h0B07_0000_0000};
    vecs[4] = '{1'b1, 2'd2, REG_DISP_TEST,  8'h00, 48'h0F00_0F00_0F00};
    vecs[5] = '{1'b0, 2'd0, REG_DIGIT0,     8'h05, 48'h0000_0000_0105};

    // Power-up reset
    repeat (2) @(negedge i_clk);
    check_idle_outputs("powerup_outputs");
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    check_idle_outputs("idle_outputs");

    // Reset while idle
    i_reset = 1'b1;
    @(negedge i_clk);
    check_idle_outputs("idle_reset_outputs");
    i_reset = 1'b0;
    repeat (3) @(negedge i_clk);
    check("idle_reset_no_load", 64'(obs_q.size()), 64'd0);

    for (int i = 0; i < 5; i++) do_frame(vecs[i], 0, $sformatf("vec%0d", i));

    // Strobe 10 cycles into a frame is dropped
    vh = '{1'b0, 2'd2, REG_DIGIT2, 8'h42, 48'h0342_0000_0000};
    do_frame(vh, 10, "inject");

    // Strobe held high: next frame starts in the IDLE cycle after DONE
    vh = '{1'b0, 2'd1, REG_DIGIT3, 8'h24, 48'h0000_0424_0000};
    a0 = ack_total;
    exp_q.push_back(vh.frame);
    exp_q.push_back(vh.frame);
    @(negedge i_clk);
    i_stb = 1'b1; i_broadcast = vh.bc; i_dev_sel = vh.sel; i_addr = vh.addr; i_data = vh.data;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge i_clk);
      if (o_ack) seen = 1'b1;
    end
    check("held_first_ack", 64'(seen), 64'd1);
    @(negedge i_clk);
    check("held_gap_idle", 64'(o_busy), 64'd0);
    @(negedge i_clk);
    check("held_restart", 64'(o_busy), 64'd1);
    i_stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge i_clk);
      if (o_ack) seen = 1'b1;
    end
    repeat (3) @(negedge i_clk);
    check("held_ack_count", 64'(ack_total - a0), 64'd2);
    check("held_load_count", 64'(obs_q.size()), 64'd2);
    pop_compare("held_f1");
    pop_compare("held_f2");
    update_regs(vh);
    check_regs("held_regs");

    // Reset at bit 20 of a dev0 write: nothing latched
    vh = '{1'b0, 2'd0, REG_DIGIT1, 8'h33, 48'h0000_0000_0233};
    launch(vh);
    for (int i = 0; i < 300 && rises < 20; i++) @(negedge i_clk);
    check("abort_reached_bit20", 64'(rises), 64'd20);
    i_reset = 1'b1;
    @(negedge i_clk);
    check_idle_outputs("abort_reset_outputs");
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (5) @(negedge i_clk);
    check("abort_no_load", 64'(obs_q.size()), 64'd0);
    check_regs("abort_regs");

    do_frame(vecs[5], 0, "vec5");
    check("digit0_value", 64'(mock_reg[0][REG_DIGIT0]), 64'h05);
    check("dout_stable_high", 64'(glitch_cnt), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
